// File: rtl/pipelined_shift_unit_if.sv
// Handshake bundle for the pipelined shift unit: operation request in, shifted result out.
// The master is the upstream/downstream side; the slave is the shift unit itself.
interface pipelined_shift_unit_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_dir;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_dir, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipelined_shift_unit.sv
// Five-stage elastic barrel shifter: stage k shifts by 2^(4-k) when its shamt bit is set.
// Logical left (dir=0) or arithmetic right (dir=1), with valid/ready backpressure.
module pipelined_shift_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 4
) (
    input logic                   clock,
    input logic                   reset_n,
    pipelined_shift_unit_if.slave bus
);
    localparam int NSTAGE = SHAMT_W;

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        logic               dir;
        logic [TAG_W-1:0]   tag;
    } stage_t;

    stage_t          src;
    stage_t          stg [NSTAGE];
    logic [NSTAGE:0] rdy;

    assign src = '{valid: bus.in_valid, data: bus.in_data, shamt: bus.in_shamt,
                   dir: bus.in_dir, tag: bus.in_tag};

    // A stage can take a new entry when it is empty or its occupant moves on,
    // so bubbles collapse as backpressure ripples from the output to the input.
    always_comb begin
        rdy[NSTAGE] = bus.out_ready;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            rdy[k] = !stg[k].valid || rdy[k + 1];
        end
    end

    assign bus.in_ready = rdy[0];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int BIT = NSTAGE - 1 - k;
        localparam int AMT = 1 << BIT;

        stage_t prev;
        stage_t nxt;
        stage_t q;

        if (k == 0) begin : g_first
            assign prev = src;
        end else begin : g_rest
            assign prev = stg[k - 1];
        end

        // NOTE: default the whole struct first so no field can infer a latch.
        always_comb begin
            nxt = prev;
            if (prev.shamt[BIT]) begin
                nxt.data = prev.dir ? DATA_W'($signed(prev.data) >>> AMT)
                                    : prev.data << AMT;
            end
        end

        // NOTE: non-blocking updates so every stage samples its predecessor's old value.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q <= '0;
            end else if (rdy[k]) begin
                if (prev.valid) begin
                    q <= nxt;
                end else begin
                    q.valid <= 1'b0;
                end
            end
        end

        assign stg[k] = q;
    end

    assign bus.out_valid = stg[NSTAGE - 1].valid;
    assign bus.out_data  = stg[NSTAGE - 1].data;
    assign bus.out_tag   = stg[NSTAGE - 1].tag;
endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Self-checking bench for pipelined_shift_unit: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, and a long random run.
module tb_pipelined_shift_unit;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    pipelined_shift_unit_if #(.DATA_W(32), .SHAMT_W(5), .TAG_W(4)) bus ();

    pipelined_shift_unit #(.DATA_W(32), .SHAMT_W(5), .TAG_W(4)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference shift straight from the arithmetic definition.
    function automatic logic [31:0] model(input logic [31:0] a, input int s, input logic d);
        if (d) return 32'($signed(a) >>> s);
        return a << s;
    endfunction

    // Scoreboard: accepted operations queue up as {tag, expected data}.
    logic [35:0] expq [$];
    logic        prev_hold = 1'b0;
    logic [36:0] prev_snap = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            prev_hold = 1'b0;
            check("out_valid_in_reset", {63'd0, bus.out_valid}, 64'd0);
        end else begin
            if (prev_hold) begin
                check("stall_hold", {27'd0, bus.out_valid, bus.out_tag, bus.out_data},
                      {27'd0, prev_snap});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_output", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    check("result", {28'd0, bus.out_tag, bus.out_data}, {28'd0, expq.pop_front()});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back({bus.in_tag, model(bus.in_data, int'(bus.in_shamt), bus.in_dir)});
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_snap = {bus.out_valid, bus.out_tag, bus.out_data};
        end
    end

    // Presents one operation and holds it stable until the unit accepts it.
    task automatic send(input logic [31:0] a, input logic [4:0] s, input logic d, input logic [3:0] t);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = a;
        bus.in_shamt = s;
        bus.in_dir   = d;
        bus.in_tag   = t;
        @(negedge clk);
        while (!bus.in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.out_valid) check(name, 64'd0, 64'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.out_ready = 1'b1;
        while (expq.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(expq.size()), 64'd0);
    endtask

    logic [31:0] stream_exp [4];
    logic [31:0] held;
    int          accepts;
    int          seen;
    int          lat;
    bit          done;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_dir    = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Pin the reference model against hand-computed values.
        check("model_asr_2",   64'(model(32'h80000001, 2, 1'b1)), 64'hE0000000);
        check("model_lsl_2",   64'(model(32'h80000001, 2, 1'b0)), 64'h00000004);
        check("model_asr_31",  64'(model(32'h80000000, 31, 1'b1)), 64'hFFFFFFFF);
        check("model_lsl_31",  64'(model(32'h00000001, 31, 1'b0)), 64'h80000000);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_out_data",  64'(bus.out_data), 64'd0);
        check("reset_out_tag",   64'(bus.out_tag), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

        // Single operation: latency and value, both directions.
        send(32'h80000001, 5'd2, 1'b1, 4'd3);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency_cycles", 64'(lat), 64'd5);
        check("single_asr_data", 64'(bus.out_data), 64'hE0000000);
        check("single_asr_tag",  64'(bus.out_tag), 64'd3);
        send(32'h80000001, 5'd2, 1'b0, 4'd3);
        wait_out("single_lsl_timeout");
        check("single_lsl_data", 64'(bus.out_data), 64'h00000004);
        drain("single_drain");

        // Streaming back-to-back with the output always ready.
        stream_exp[0] = 32'h000000F0;
        stream_exp[1] = 32'hFF000000;
        stream_exp[2] = 32'h12345678;
        stream_exp[3] = 32'h00000000;
        send(32'h0000000F, 5'd4,  1'b0, 4'd0);
        send(32'hF0000000, 5'd4,  1'b1, 4'd1);
        send(32'h12345678, 5'd0,  1'b0, 4'd2);
        send(32'h7FFFFFFF, 5'd31, 1'b1, 4'd3);
        wait_out("stream_timeout");
        for (int i = 0; i < 4; i++) begin
            check("stream_valid", {63'd0, bus.out_valid}, 64'd1);
            check("stream_data", 64'(bus.out_data), 64'(stream_exp[i]));
            @(posedge clk);
            #1;
        end
        drain("stream_drain");

        // Backpressure: the unit fills to five entries and then stops accepting.
        bus.out_ready = 1'b0;
        accepts       = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = $urandom;
        bus.in_shamt  = 5'($urandom_range(0, 31));
        bus.in_dir    = 1'($urandom_range(0, 1));
        bus.in_tag    = 4'd0;
        for (int c = 0; c < 10; c++) begin
            bit took;
            @(negedge clk);
            took = bus.in_ready;
            if (took) accepts++;
            @(posedge clk);
            #1;
            if (took) begin
                bus.in_data  = $urandom;
                bus.in_shamt = 5'($urandom_range(0, 31));
                bus.in_dir   = 1'($urandom_range(0, 1));
                bus.in_tag   = 4'(accepts);
            end
        end
        check("bp_accepts", 64'(accepts), 64'd5);
        check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
        bus.in_valid = 1'b0;
        held = bus.out_data;
        repeat (2) @(posedge clk);
        #1;
        check("bp_out_data_stable", 64'(bus.out_data), 64'(held));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_release_valid", {63'd0, bus.out_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        check("bp_empty_after", {63'd0, bus.out_valid}, 64'd0);
        check("bp_queue_empty", 64'(expq.size()), 64'd0);

        // Corners: every shift amount on single-bit operands, both directions.
        for (int i = 0; i < 128; i++) begin
            send((i[6]) ? 32'h00000001 : 32'h80000000, 5'(i), i[5], 4'(i));
        end
        drain("corner_drain");

        // Reset with three operations in flight discards them.
        bus.out_ready = 1'b0;
        send(32'h11111111, 5'd1, 1'b0, 4'd1);
        send(32'h22222222, 5'd2, 1'b1, 4'd2);
        send(32'h33333333, 5'd3, 1'b0, 4'd3);
        wait_out("inflight_timeout");
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midreset_out_data",  64'(bus.out_data), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        check("midreset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midreset_no_outputs", 64'(seen), 64'd0);

        // Long random run with random input gaps and random output stalls.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 99) < 30) begin
                        @(posedge clk);
                        #1;
                    end
                    send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 4'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 99) < 70);
                end
            end
        join
        drain("random_drain");
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", {63'd0, bus.out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
